// File: rtl/aes_pkg.sv
// Shared AES definitions: round count, FSM state encoding and the key-schedule
// round constant table.
package aes_pkg;

   localparam logic [3:0] AES_NR = 4'd10;

   typedef logic [0:0] state_t;
   localparam state_t ST_IDLE = 1'b0;
   localparam state_t ST_EMIT = 1'b1;

   // Rcon[round] for AES-128; rounds outside 1..10 never reach the datapath
   function automatic logic [7:0] aes_rcon(input logic [3:0] round);
      logic [7:0] rc;
      case (round)
         4'd1:    rc = 8'h01;
         4'd2:    rc = 8'h02;
         4'd3:    rc = 8'h04;
         4'd4:    rc = 8'h08;
         4'd5:    rc = 8'h10;
         4'd6:    rc = 8'h20;
         4'd7:    rc = 8'h40;
         4'd8:    rc = 8'h80;
         4'd9:    rc = 8'h1b;
         4'd10:   rc = 8'h36;
         default: rc = 8'h00;
      endcase
      return rc;
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box, purely combinational; shared by the key schedule and the
// cipher datapath.
module aes_sbox (
   input  logic [7:0] data,
   output logic [7:0] sub
);

   // Entry 0 is the leftmost byte of the table
   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   assign sub = SBOX[data];

endmodule

// File: rtl/aes_key_expander.sv
// AES-128 key expander: accepts a cipher key and streams the 11 round keys
// one per handshake. Optional zeroize wipe enabled by AES_KEY_ZEROIZE_EN.
module aes_key_expander
   import aes_pkg::*;
(
   input  logic         ACLK,
   input  logic         ARESET,
   input  logic [127:0] key,
   input  logic         key_valid,
   output logic         key_ready,
   output logic [127:0] rk_data,
   output logic [3:0]   rk_idx,
   output logic         rk_last,
   output logic         rk_valid,
   input  logic         rk_ready,
   input  logic         zeroize,
   output logic         busy
);

   state_t       state;
   logic [127:0] work;
   logic [3:0]   idx;
   logic [3:0]   next_round;
   logic [31:0]  w0, w1, w2, w3;
   logic [31:0]  rot_word, sub_word, t_word;
   logic [31:0]  n0, n1, n2, n3;

   assign w0 = work[127:96];
   assign w1 = work[95:64];
   assign w2 = work[63:32];
   assign w3 = work[31:0];

   assign rot_word = {w3[23:0], w3[31:24]};

   for (genvar g = 0; g < 4; g++) begin : g_sbox
      aes_sbox u_sbox (
         .data (rot_word[8*g +: 8]),
         .sub  (sub_word[8*g +: 8])
      );
   end

   // Next round key is formed in one pass from the currently presented key
   assign next_round = idx + 4'd1;
   assign t_word     = sub_word ^ {aes_rcon(next_round), 24'h000000};
   assign n0         = w0 ^ t_word;
   assign n1         = w1 ^ n0;
   assign n2         = w2 ^ n1;
   assign n3         = w3 ^ n2;

   assign key_ready = (state == ST_IDLE);
   assign rk_valid  = (state == ST_EMIT);
   assign busy      = (state != ST_IDLE);
   assign rk_data   = work;
   assign rk_idx    = idx;
   assign rk_last   = (state == ST_EMIT) && (idx == AES_NR);

`ifndef AES_KEY_ZEROIZE_EN
   logic zeroize_unused;
   assign zeroize_unused = zeroize;
`endif

   // Wipe (when built in) outranks both key load and beat advance
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state <= ST_IDLE;
         work  <= '0;
         idx   <= '0;
      end
`ifdef AES_KEY_ZEROIZE_EN
      else if (zeroize) begin
         state <= ST_IDLE;
         work  <= '0;
         idx   <= '0;
      end
`endif
      else begin
         case (state)
            ST_IDLE: begin
               if (key_valid) begin
                  work  <= key;
                  idx   <= '0;
                  state <= ST_EMIT;
               end
            end
            ST_EMIT: begin
               if (rk_ready) begin
                  if (idx == AES_NR) begin
                     state <= ST_IDLE;
                  end else begin
                     work <= {n0, n1, n2, n3};
                     idx  <= next_round;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_key_expander.sv
// Directed bench for aes_key_expander using FIPS-197 and all-zero key schedules.
module tb_aes_key_expander;

   logic         ACLK;
   logic         ARESET;
   logic [127:0] key;
   logic         key_valid;
   logic         key_ready;
   logic [127:0] rk_data;
   logic [3:0]   rk_idx;
   logic         rk_last;
   logic         rk_valid;
   logic         rk_ready;
   logic         zeroize;
   logic         busy;

   int check_count = 0;
   int error_count = 0;

   localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] ZERO_RK1 = 128'h62636363626363636263636362636363;
   localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

   aes_key_expander dut (
      .ACLK      (ACLK),
      .ARESET    (ARESET),
      .key       (key),
      .key_valid (key_valid),
      .key_ready (key_ready),
      .rk_data   (rk_data),
      .rk_idx    (rk_idx),
      .rk_last   (rk_last),
      .rk_valid  (rk_valid),
      .rk_ready  (rk_ready),
      .zeroize   (zeroize),
      .busy      (busy)
   );

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // FIPS-197 Appendix A.1 round keys
   function automatic logic [127:0] fipsKey(input int i);
      case (i)
         0:  return 128'h2b7e151628aed2a6abf7158809cf4f3c;
         1:  return 128'ha0fafe1788542cb123a339392a6c7605;
         2:  return 128'hf2c295f27a96b9435935807a7359f67f;
         3:  return 128'h3d80477d4716fe3e1e237e446d7a883b;
         4:  return 128'hef44a541a8525b7fb671253bdb0bad00;
         5:  return 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
         6:  return 128'h6d88a37a110b3efddbf98641ca0093fd;
         7:  return 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
         8:  return 128'head27321b58dbad2312bf5607f8d292f;
         9:  return 128'hac7766f319fadc2128d12941575c006e;
         10: return 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
         default: return 128'h0;
      endcase
   endfunction

   task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
      check_count++;
      if (observed !== expected) begin
         error_count++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [127:0] k);
      @(negedge ACLK);
      checkOutput("key_ready_idle", 128'(key_ready), 128'(1));
      key       = k;
      key_valid = 1'b1;
      @(negedge ACLK);
      key_valid = 1'b0;
   endtask

   // Called at the negedge showing idx0; rk_ready must already be high
   task automatic expectSequence(input bit use_fips);
      for (int i = 0; i <= 10; i++) begin
         checkOutput($sformatf("rk_valid[%0d]", i), 128'(rk_valid), 128'(1));
         checkOutput($sformatf("rk_idx[%0d]", i), 128'(rk_idx), 128'(i));
         checkOutput($sformatf("rk_last[%0d]", i), 128'(rk_last), 128'(i == 10));
         checkOutput($sformatf("key_ready_emit[%0d]", i), 128'(key_ready), 128'(0));
         checkOutput($sformatf("busy_emit[%0d]", i), 128'(busy), 128'(1));
         if (use_fips)
            checkOutput($sformatf("rk_data_fips[%0d]", i), rk_data, fipsKey(i));
         else if (i == 0)
            checkOutput("rk_data_zero[0]", rk_data, 128'h0);
         else if (i == 1)
            checkOutput("rk_data_zero[1]", rk_data, ZERO_RK1);
         else if (i == 10)
            checkOutput("rk_data_zero[10]", rk_data, ZERO_RK10);
         if (i < 10) @(negedge ACLK);
      end
      @(negedge ACLK);
      checkOutput("rk_valid_after", 128'(rk_valid), 128'(0));
      checkOutput("key_ready_after", 128'(key_ready), 128'(1));
      checkOutput("busy_after", 128'(busy), 128'(0));
   endtask

   initial begin
      int beats;
      bit done;

      ARESET    = 1'b1;
      key       = '0;
      key_valid = 1'b0;
      rk_ready  = 1'b1;
      zeroize   = 1'b0;

      // Reset state
      @(negedge ACLK);
      checkOutput("reset_key_ready", 128'(key_ready), 128'(1));
      checkOutput("reset_rk_valid", 128'(rk_valid), 128'(0));
      checkOutput("reset_rk_last", 128'(rk_last), 128'(0));
      checkOutput("reset_busy", 128'(busy), 128'(0));
      checkOutput("reset_rk_data", rk_data, 128'h0);
      checkOutput("reset_rk_idx", 128'(rk_idx), 128'(0));
      @(negedge ACLK);
      ARESET = 1'b0;

      $display("[TB] FIPS-197 key, back-to-back");
      applyStimulus(FIPS_KEY);
      expectSequence(1'b1);

      $display("[TB] all-zero key");
      applyStimulus(128'h0);
      expectSequence(1'b0);

      $display("[TB] random rk_ready stalls");
      applyStimulus(FIPS_KEY);
      beats = 0;
      done  = 1'b0;
      for (int c = 0; c < 300 && !done; c++) begin
         if (rk_valid) begin
            checkOutput("stall_idx", 128'(rk_idx), 128'(beats));
            checkOutput("stall_data", rk_data, fipsKey(beats));
         end
         rk_ready = 1'($urandom_range(0, 1));
         if (rk_valid && rk_ready) begin
            beats++;
            if (beats == 11) done = 1'b1;
         end
         @(negedge ACLK);
      end
      checkOutput("stall_handshakes", 128'(beats), 128'(11));
      checkOutput("stall_idle_after", 128'(rk_valid), 128'(0));
      rk_ready = 1'b1;

      $display("[TB] reset at idx5");
      applyStimulus(FIPS_KEY);
      for (int i = 0; i < 5; i++) @(negedge ACLK);
      checkOutput("pre_reset_idx", 128'(rk_idx), 128'(5));
      ARESET = 1'b1;
      #1;
      checkOutput("async_reset_rk_valid", 128'(rk_valid), 128'(0));
      checkOutput("async_reset_key_ready", 128'(key_ready), 128'(1));
      checkOutput("async_reset_rk_data", rk_data, 128'h0);
      checkOutput("async_reset_busy", 128'(busy), 128'(0));
      @(negedge ACLK);
      ARESET = 1'b0;
      applyStimulus(FIPS_KEY);
      expectSequence(1'b1);

      $display("[TB] zeroize at idx3 while stalled");
      applyStimulus(FIPS_KEY);
      for (int i = 0; i <= 3; i++) begin
         checkOutput("zeroize_pre_idx", 128'(rk_idx), 128'(i));
         if (i < 3) @(negedge ACLK);
      end
      rk_ready = 1'b0;
      zeroize  = 1'b1;
      @(negedge ACLK);
      zeroize = 1'b0;
`ifdef AES_KEY_ZEROIZE_EN
      checkOutput("zeroize_rk_valid", 128'(rk_valid), 128'(0));
      checkOutput("zeroize_key_ready", 128'(key_ready), 128'(1));
      checkOutput("zeroize_rk_data", rk_data, 128'h0);
      checkOutput("zeroize_rk_idx", 128'(rk_idx), 128'(0));
      rk_ready = 1'b1;
`else
      checkOutput("zeroize_ignored_idx", 128'(rk_idx), 128'(3));
      checkOutput("zeroize_ignored_data", rk_data, fipsKey(3));
      rk_ready = 1'b1;
      for (int i = 3; i <= 10; i++) begin
         checkOutput("zeroize_ignored_seq_idx", 128'(rk_idx), 128'(i));
         checkOutput("zeroize_ignored_seq_data", rk_data, fipsKey(i));
         @(negedge ACLK);
      end
      checkOutput("zeroize_ignored_done", 128'(rk_valid), 128'(0));
`endif

      $display("[TB] key_valid held through EMIT");
      @(negedge ACLK);
      key       = FIPS_KEY;
      key_valid = 1'b1;
      @(negedge ACLK);
      expectSequence(1'b1);
      key = 128'h0;
      @(negedge ACLK);
      key_valid = 1'b0;
      checkOutput("second_key_valid", 128'(rk_valid), 128'(1));
      checkOutput("second_key_idx0", 128'(rk_idx), 128'(0));
      checkOutput("second_key_data0", rk_data, 128'h0);
      @(negedge ACLK);
      checkOutput("second_key_data1", rk_data, ZERO_RK1);
      for (int c = 0; c < 20 && rk_valid; c++) @(negedge ACLK);
      checkOutput("second_key_drained", 128'(rk_valid), 128'(0));

      $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
      $finish;
   end

endmodule
